// File: rtl/board_editor.sv
`default_nettype none
// ============================================================================
// Module   : board_editor
// Purpose  : Write side of the board memory: cursor toggles by read-modify-
//            write and whole-board clears, confined to the blanking window.
//            Optional macro BOARD_EDIT_COUNT_EN adds the edit_count_out port.
// Revision : 1.0  initial release
// ============================================================================
module board_editor #(
    parameter int WORD_SIZE      = 16,
    parameter int LOG_WORD_SIZE  = 4,
    parameter int BOARD_SIZE     = 256,
    parameter int LOG_BOARD_SIZE = 8,
    parameter int LOG_MAX_ADDR   = 12,
    parameter int READ_LATENCY   = 2
) (
    input  logic                      clk_130mhz,
    input  logic                      rst_n_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    input  logic                      toggle_in,
    input  logic                      clear_in,
    input  logic                      done_in,
    input  logic [WORD_SIZE-1:0]      data_r_in,
    output logic [LOG_MAX_ADDR-1:0]   addr_out,
    output logic [WORD_SIZE-1:0]      data_w_out,
    output logic                      we_out,
    output logic                      busy_out,
`ifdef BOARD_EDIT_COUNT_EN
    output logic [15:0]               edit_count_out,
`endif
    output logic                      edit_done_out
);

    localparam int                      c_LAT_W     = $clog2(READ_LATENCY + 1);
    localparam logic [c_LAT_W-1:0]      c_LAT_LAST  = c_LAT_W'(READ_LATENCY - 1);
    localparam logic [LOG_MAX_ADDR-1:0] c_LAST_ADDR = LOG_MAX_ADDR'(BOARD_SIZE * BOARD_SIZE / WORD_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_WIN_T = 3'd1,
        S_READ       = 3'd2,
        S_WAIT_DATA  = 3'd3,
        S_WRITE      = 3'd4,
        S_CLEAR      = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [LOG_BOARD_SIZE-1:0] r_cur_x;
    logic [LOG_BOARD_SIZE-1:0] r_cur_y;
    logic [LOG_MAX_ADDR-1:0]   r_clr_ptr;
    logic [WORD_SIZE-1:0]      r_wdata;
    logic [c_LAT_W-1:0]        r_lat_cnt;
    logic                      r_edit_done;

    logic                      w_accept_t;
    logic                      w_lat_start;
    logic                      w_capture;
    logic                      w_clr_step;
    logic                      w_finish;
    logic [LOG_MAX_ADDR-1:0]   w_edit_addr;
    logic [LOG_WORD_SIZE-1:0]  w_bit_idx;
    logic [WORD_SIZE-1:0]      w_mask;

    // Row-major word address; leftmost cell of a word sits in its MSB, so the
    // bit index WORD_SIZE-1-x reduces to the inverted low column bits.
    assign w_edit_addr = {r_cur_y, r_cur_x[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]};
    assign w_bit_idx   = ~r_cur_x[LOG_WORD_SIZE-1:0];
    assign w_mask      = {{(WORD_SIZE-1){1'b0}}, 1'b1} << w_bit_idx;

    assign busy_out      = (r_state != S_IDLE);
    assign edit_done_out = r_edit_done;

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        addr_out    = '0;
        data_w_out  = '0;
        we_out      = 1'b0;
        w_accept_t  = 1'b0;
        w_lat_start = 1'b0;
        w_capture   = 1'b0;
        w_clr_step  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_in) begin
                    w_next = S_CLEAR;
                end else if (toggle_in) begin
                    w_next     = S_WAIT_WIN_T;
                    w_accept_t = 1'b1;
                end
            end
            S_WAIT_WIN_T: begin
                if (done_in) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                addr_out = w_edit_addr;
                if (done_in) begin
                    w_next      = S_WAIT_DATA;
                    w_lat_start = 1'b1;
                end else begin
                    w_next = S_WAIT_WIN_T;
                end
            end
            S_WAIT_DATA: begin
                addr_out = w_edit_addr;
                if (!done_in) begin
                    w_next = S_WAIT_WIN_T;
                end else if (r_lat_cnt == c_LAT_LAST) begin
                    w_next    = S_WRITE;
                    w_capture = 1'b1;
                end
            end
            S_WRITE: begin
                addr_out   = w_edit_addr;
                data_w_out = r_wdata;
                // A window that closed after capture forces a fresh read.
                if (done_in) begin
                    we_out   = 1'b1;
                    w_finish = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_next = S_WAIT_WIN_T;
                end
            end
            S_CLEAR: begin
                addr_out = r_clr_ptr;
                if (done_in) begin
                    we_out     = 1'b1;
                    w_clr_step = 1'b1;
                    if (r_clr_ptr == c_LAST_ADDR) begin
                        w_finish = 1'b1;
                        w_next   = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_clr_ptr   <= '0;
            r_wdata     <= '0;
            r_lat_cnt   <= '0;
            r_edit_done <= 1'b0;
        end else begin
            r_edit_done <= w_finish;
            if (w_accept_t) begin
                r_cur_x <= cursor_x_in;
                r_cur_y <= cursor_y_in;
            end
            if (w_lat_start) begin
                r_lat_cnt <= '0;
            end else if (r_state == S_WAIT_DATA) begin
                r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
            end
            if (w_capture) begin
                r_wdata <= data_r_in ^ w_mask;
            end
            if (w_clr_step) begin
                r_clr_ptr <= (r_clr_ptr == c_LAST_ADDR) ? '0 : r_clr_ptr + LOG_MAX_ADDR'(1);
            end
        end
    end

`ifdef BOARD_EDIT_COUNT_EN
    logic [15:0] r_edit_count;

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_edit_count <= '0;
        end else if (w_finish) begin
            r_edit_count <= r_edit_count + 16'd1;
        end
    end

    assign edit_count_out = r_edit_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_board_editor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_board_editor
// Purpose  : Self-checking bench for board_editor with a latency-2 memory and
//            a cell-level board model.
// Revision : 1.0  initial release
// ============================================================================
module tb_board_editor;

    localparam int NWORDS = 4096;

    logic        clk_130mhz = 1'b0;
    logic        rst_n_in;
    logic [7:0]  cursor_x_in;
    logic [7:0]  cursor_y_in;
    logic        toggle_in;
    logic        clear_in;
    logic        done_in;
    logic [15:0] data_r_in;
    logic [11:0] addr_out;
    logic [15:0] data_w_out;
    logic        we_out;
    logic        busy_out;
    logic        edit_done_out;
`ifdef BOARD_EDIT_COUNT_EN
    logic [15:0] edit_count_out;
`endif

    always #4 clk_130mhz = ~clk_130mhz;

    board_editor dut (
        .clk_130mhz    (clk_130mhz),
        .rst_n_in      (rst_n_in),
        .cursor_x_in   (cursor_x_in),
        .cursor_y_in   (cursor_y_in),
        .toggle_in     (toggle_in),
        .clear_in      (clear_in),
        .done_in       (done_in),
        .data_r_in     (data_r_in),
        .addr_out      (addr_out),
        .data_w_out    (data_w_out),
        .we_out        (we_out),
        .busy_out      (busy_out),
`ifdef BOARD_EDIT_COUNT_EN
        .edit_count_out(edit_count_out),
`endif
        .edit_done_out (edit_done_out)
    );

    // Board memory: registered read through two stages, read-old on collision.
    logic [15:0] mem [0:NWORDS-1];
    logic [15:0] rd1;
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk_130mhz) begin
        rd1       <= mem[addr_out];
        data_r_in <= rd1;
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (we_out) mem[addr_out] <= data_w_out;
    end

    logic [11:0] wa_q [$];
    logic [15:0] wd_q [$];
    int          blank_we = 0;

    always @(negedge clk_130mhz) begin
        if (we_out === 1'b1) begin
            wa_q.push_back(addr_out);
            wd_q.push_back(data_w_out);
            if (done_in !== 1'b1) blank_we++;
        end
    end

    // Cell-level model of the board contents.
    bit gold [0:255][0:255];

    int total = 0;
    int bad   = 0;
    int n_edits = 0;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        bit          load;
        logic [15:0] init;
        logic [11:0] addr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_130mhz);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic pulse_toggle(input logic [7:0] x, input logic [7:0] y);
        cursor_x_in = x;
        cursor_y_in = y;
        toggle_in   = 1'b1;
        step();
        toggle_in   = 1'b0;
        cursor_x_in = ~x;
        cursor_y_in = ~y;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_130mhz);
            if (edit_done_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            if (rnd) done_in = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic run_clear(input bit blink, input bit tog_same, input bit tog_during, output bit ok);
        clear_in  = 1'b1;
        toggle_in = tog_same;
        step();
        clear_in  = 1'b0;
        toggle_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_130mhz);
            if (edit_done_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            toggle_in = tog_during && (i == 10 || i == 300);
            if (blink) done_in = (((i / 50) % 2) != 0);
        end
        toggle_in = 1'b0;
    endtask

    task automatic check_clear(input string name, input int base);
        int errs = 0;
        check({name, "_writes"}, wa_q.size() - base, NWORDS);
        for (int k = 0; k < NWORDS && base + k < wa_q.size(); k++) begin
            if (wa_q[base + k] !== 12'(k) || wd_q[base + k] !== 16'h0000) errs++;
        end
        check({name, "_order"}, errs, 0);
    endtask

    function automatic logic [15:0] gold_word(input int x, input int y);
        logic [15:0] w = '0;
        for (int b = 0; b < 16; b++) w[15 - b] = gold[y][(x / 16) * 16 + b];
        return w;
    endfunction

    initial begin
        int  base;
        int  nz;
        int  rx, ry;
        bit  ok;
        logic [15:0] expw;

        vecs[0] = '{8'd5,   8'd3,   1'b1, 16'h0000, 12'd48,   16'h0400};
        vecs[1] = '{8'd17,  8'd0,   1'b1, 16'hFFFF, 12'd1,    16'hBFFF};
        vecs[2] = '{8'd17,  8'd0,   1'b0, 16'h0000, 12'd1,    16'hFFFF};
        vecs[3] = '{8'd0,   8'd0,   1'b1, 16'h0000, 12'd0,    16'h8000};
        vecs[4] = '{8'd15,  8'd0,   1'b1, 16'h0000, 12'd0,    16'h0001};
        vecs[5] = '{8'd255, 8'd255, 1'b1, 16'h1234, 12'd4095, 16'h1235};
        vecs[6] = '{8'd152, 8'd10,  1'b1, 16'hAAAA, 12'd169,  16'hAA2A};

        rst_n_in    = 1'b0;
        cursor_x_in = '0;
        cursor_y_in = '0;
        toggle_in   = 1'b0;
        clear_in    = 1'b0;
        done_in     = 1'b1;
        repeat (3) step();
        @(negedge clk_130mhz);
        check("rst_addr", addr_out, 0);
        check("rst_data_w", data_w_out, 0);
        check("rst_we", we_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_edit_done", edit_done_out, 0);
`ifdef BOARD_EDIT_COUNT_EN
        check("rst_edit_count", edit_count_out, 0);
`endif
        step();
        rst_n_in = 1'b1;
        step();

        // Single toggles against known word contents.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].load) preload(vecs[i].addr, vecs[i].init);
            base = wa_q.size();
            pulse_toggle(vecs[i].x, vecs[i].y);
            @(negedge clk_130mhz);
            check("vec_busy_rise", busy_out, 1);
            wait_done(40, 1'b0, ok);
            check("vec_done", ok, 1);
            if (ok) n_edits++;
            check("vec_we_count", wa_q.size() - base, 1);
            if (wa_q.size() > base) begin
                check("vec_addr", wa_q[base], vecs[i].addr);
                check("vec_wdata", wd_q[base], vecs[i].wdata);
            end
            step();
            @(negedge clk_130mhz);
            check("vec_busy_fall", busy_out, 0);
            check("vec_mem", mem[vecs[i].addr], vecs[i].wdata);
        end

        // Toggle held off by a closed window, then an abort inside the read.
        done_in = 1'b0;
        preload(12'd114, 16'h1111);
        base = wa_q.size();
        pulse_toggle(8'd40, 8'd7);
        repeat (100) step();
        @(negedge clk_130mhz);
        check("blank_busy", busy_out, 1);
        check("blank_no_write", wa_q.size() - base, 0);
        step();
        done_in = 1'b1;
        wait_done(40, 1'b0, ok);
        check("blank_done", ok, 1);
        if (ok) n_edits++;
        check("blank_mem", mem[114], 16'h1191);

        base = wa_q.size();
        step();
        pulse_toggle(8'd40, 8'd7);
        step();
        step();
        done_in = 1'b0;
        repeat (20) step();
        preload(12'd114, 16'h00F0);
        @(negedge clk_130mhz);
        check("abort_no_write", wa_q.size() - base, 0);
        check("abort_busy", busy_out, 1);
        step();
        done_in = 1'b1;
        wait_done(40, 1'b0, ok);
        check("abort_done", ok, 1);
        if (ok) n_edits++;
        check("abort_we_count", wa_q.size() - base, 1);
        check("abort_reread_mem", mem[114], 16'h0070);
        check("no_we_blank_a", blank_we, 0);

        // Full clear with steady window; toggles during it are dropped.
        step();
        cursor_x_in = 8'd33;
        cursor_y_in = 8'd44;
        base = wa_q.size();
        run_clear(1'b0, 1'b0, 1'b1, ok);
        check("clear_done", ok, 1);
        if (ok) n_edits++;
        repeat (30) step();
        check_clear("clear_steady", base);
        @(negedge clk_130mhz);
        check("clear_idle_busy", busy_out, 0);
        nz = 0;
        for (int k = 0; k < NWORDS; k++) if (mem[k] !== 16'h0000) nz++;
        check("clear_mem_zero", nz, 0);

        // Randomized toggles with a flickering window against the cell model.
        for (int yy = 0; yy < 256; yy++)
            for (int xx = 0; xx < 256; xx++) gold[yy][xx] = 1'b0;
        rx = 0;
        ry = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 5 != 4) begin
                rx = $urandom_range(0, 255);
                ry = $urandom_range(0, 255);
            end
            step();
            base = wa_q.size();
            pulse_toggle(8'(rx), 8'(ry));
            wait_done(600, 1'b1, ok);
            check("rand_done", ok, 1);
            if (ok) n_edits++;
            gold[ry][rx] = ~gold[ry][rx];
            expw = gold_word(rx, ry);
            check("rand_one_write", wa_q.size() - base, 1);
            check("rand_word", mem[ry * 16 + rx / 16], expw);
            done_in = 1'b1;
        end
        check("no_we_blank_b", blank_we, 0);

        // Clear with window toggling every 50 cycles.
        step();
        base = wa_q.size();
        run_clear(1'b1, 1'b0, 1'b0, ok);
        check("clear_blink_done", ok, 1);
        if (ok) n_edits++;
        done_in = 1'b1;
        check_clear("clear_blink", base);
        nz = 0;
        for (int k = 0; k < NWORDS; k++) if (mem[k] !== 16'h0000) nz++;
        check("clear_blink_mem_zero", nz, 0);
        check("no_we_blank_c", blank_we, 0);

        // Simultaneous toggle and clear: clear only.
        step();
        cursor_x_in = 8'd7;
        cursor_y_in = 8'd9;
        base = wa_q.size();
        run_clear(1'b0, 1'b1, 1'b0, ok);
        check("clear_vs_toggle_done", ok, 1);
        if (ok) n_edits++;
        repeat (30) step();
        check_clear("clear_vs_toggle", base);

        // Reset in the middle of a clear.
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_130mhz);
            if (we_out === 1'b1 && addr_out == 12'd700) begin
                rst_n_in = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        check("reach_addr_700", ok, 1);
        #1;
        n_edits = 0;
        check("midrst_we", we_out, 0);
        check("midrst_addr", addr_out, 0);
        check("midrst_data_w", data_w_out, 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_edit_done", edit_done_out, 0);
        step();
        base = wa_q.size();
        repeat (5) step();
        rst_n_in = 1'b1;
        repeat (10) step();
        check("midrst_no_write", wa_q.size() - base, 0);
        base = wa_q.size();
        run_clear(1'b0, 1'b0, 1'b0, ok);
        check("post_rst_clear_done", ok, 1);
        if (ok) n_edits++;
        check_clear("post_rst_clear", base);
`ifdef BOARD_EDIT_COUNT_EN
        @(negedge clk_130mhz);
        check("edit_count", edit_count_out, n_edits);
`endif
        check("no_we_blank_d", blank_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/board_editor.md
Name: board_editor

Overview:
Write side of the board memory that the renderer reads. It applies user edits: toggling the cell under the cursor by read-modify-write, and clearing the whole board.
- Memory is touched only while done_in (renderer blanking window) is high, so edits never collide with active-video fetches.
- Uses the same word/bit mapping as the render fetch path, so a toggled cell appears at the cursor on the next frame.

Parameters:
WORD_SIZE, 16, bits per board memory word
LOG_WORD_SIZE, 4, log2(WORD_SIZE)
BOARD_SIZE, 256, board edge length in cells
LOG_BOARD_SIZE, 8, log2(BOARD_SIZE)
LOG_MAX_ADDR, 12, address width; word count = BOARD_SIZE*BOARD_SIZE/WORD_SIZE = 4096
READ_LATENCY, 2, cycles from addr_out to valid data_r_in (BRAM with output register)

Ports:
clk_130mhz  in  1  system clock
rst_n_in  in  1  asynchronous reset, active-low
cursor_x_in  in  LOG_BOARD_SIZE  cursor column, board coordinates
cursor_y_in  in  LOG_BOARD_SIZE  cursor row, board coordinates
toggle_in  in  1  one-cycle pulse: invert the cell at the cursor
clear_in  in  1  one-cycle pulse: zero the entire board
done_in  in  1  renderer blanking window; memory access is allowed only while high
data_r_in  in  WORD_SIZE  read data from board memory
addr_out  out  LOG_MAX_ADDR  read/write address
data_w_out  out  WORD_SIZE  write data
we_out  out  1  write enable, one cycle per word
busy_out  out  1  an edit is pending or in progress
edit_done_out  out  1  one-cycle pulse when an edit completes

Behaviour:
- Reset: async assert when rst_n_in=0. All outputs 0, FSM=IDLE, latched cursor=0, clear pointer=0.
- Addressing:
  - addr = y*(BOARD_SIZE/WORD_SIZE) + (x >> LOG_WORD_SIZE).
  - Bit index = WORD_SIZE-1 - x[LOG_WORD_SIZE-1:0] (MSB = leftmost cell).
- Request acceptance:
  - Requests are sampled only in IDLE.
  - In IDLE, cursor_x_in/cursor_y_in are latched on toggle_in.
  - Pulses arriving while busy_out=1 are dropped, not queued.
  - toggle_in and clear_in in the same cycle: clear wins, toggle dropped.
  - busy_out rises the cycle after acceptance and stays high until the edit_done_out cycle.
- FSM states and transitions:
  - IDLE: toggle_in → WAIT_WIN_T; clear_in → CLEAR.
  - WAIT_WIN_T: wait for done_in=1, then → READ.
  - READ: drive the latched address for one cycle, we_out=0, start latency counter → WAIT_DATA.
  - WAIT_DATA: count READ_LATENCY cycles, holding addr_out. If done_in falls at any point → WAIT_WIN_T (abort, no write; RMW restarts from READ when the window reopens).
  - WRITE: data_w_out = data_r_in XOR one-hot(bit), captured on the data-valid cycle; we_out=1 for exactly one cycle. Next cycle edit_done_out=1 → IDLE.
  - CLEAR: each cycle with done_in=1, write 0 to the pointer address with we_out=1, then increment the pointer.
    - done_in=0: we_out=0, pointer holds; resume at the same address.
    - After writing address 2^LOG_MAX_ADDR-1, pointer wraps to 0, edit_done_out pulses → IDLE.
- we_out is never high while done_in=0, and never high in READ or WAIT_DATA.
- Cursor inputs changing mid-edit have no effect; the latched copy is used.
- Reset mid-operation: immediate abort, no further writes, clear pointer returns to 0.

Optional Feature:
BOARD_EDIT_COUNT_EN
- Defined:
  - Adds output edit_count_out [15:0], reset 0.
  - Increments on every edit_done_out; wraps 16'hFFFF→0.
  - Aborted or restarted RMW attempts do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Toggle at x=5,y=3 with done_in=1, memory[48]=16'h0000:
   - addr_out=48 in READ.
   - After READ_LATENCY, one we_out with data_w_out=16'h0400.
   - edit_done_out pulses; busy_out falls.
2. Toggle at x=17,y=0 with memory[1]=16'hFFFF → write 16'hBFFF to addr 1. Repeating the toggle restores 16'hFFFF.
3. Toggle issued with done_in=0 for 100 cycles → no we_out, busy_out=1. Raise done_in → RMW completes. Drop done_in during WAIT_DATA → no write; RMW re-reads after the window reopens.
4. clear_in with done_in held high → exactly 4096 we_out cycles, addresses 0..4095 in order, data 0, then one edit_done_out. Toggle pulses during the clear are ignored.
5. clear_in with done_in toggling high/low every 50 cycles → no address skipped or repeated, and no we_out while done_in=0.
6. toggle_in and clear_in in the same cycle → clear only. rst_n_in low mid-clear at address 700 → outputs 0 immediately; a new clear after reset starts at address 0.
